// File: rtl/apb_bridge_pkg.sv
// Shared types, field layout and constants for the APB bridge master sequencer.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_t;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    // Request entry layout, MSB to LSB: {write, addr, wdata, strb}
    localparam int REQ_STRB_LSB = 0;

    function automatic int req_w(input int aw, input int dw);
        return aw + dw + dw / 8 + 1;
    endfunction

    function automatic int req_wdata_lsb(input int dw);
        return dw / 8;
    endfunction

    function automatic int req_addr_lsb(input int dw);
        return dw + dw / 8;
    endfunction

    function automatic int req_write_bit(input int aw, input int dw);
        return aw + dw + dw / 8;
    endfunction

    // Response entry layout, MSB to LSB: {slverr, rdata}
    localparam int RSP_RDATA_LSB = 0;

    function automatic int rsp_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int rsp_slverr_bit(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB master; expire_o flags the LIMIT-th stalled cycle.
module apb_timeout_cnt #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count stalled cycles; cleared on reset and on every new transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Combinational so the FSM can pick between pready and abort in the same cycle
    assign expire_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_fsm.sv
// APB master sequencer: request FIFO -> APB SETUP/ACCESS -> response FIFO.
// Optional slave-stall abort is built when APB_MST_TIMEOUT_EN is defined.
module apb_master_fsm
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]    req_data,
    input  logic                               req_empty,
    output logic                               req_pop,
    output logic [DATA_W:0]                    rsp_data,
    input  logic                               rsp_full,
    output logic                               rsp_push,
    output logic                               psel,
    output logic                               penable,
    output logic                               pwrite,
    output logic [ADDR_W-1:0]                  paddr,
    output logic [DATA_W-1:0]                  pwdata,
    output logic [DATA_W/8-1:0]                pstrb,
    output logic [2:0]                         pprot,
    input  logic                               pready,
    input  logic                               pslverr,
    input  logic [DATA_W-1:0]                  prdata
);

    localparam int STRB_W     = DATA_W / 8;
    localparam int REQ_W      = req_w(ADDR_W, DATA_W);
    localparam int RSP_W      = rsp_w(DATA_W);
    localparam int WDATA_LSB  = req_wdata_lsb(DATA_W);
    localparam int ADDR_LSB   = req_addr_lsb(DATA_W);
    localparam int WRITE_BIT  = req_write_bit(ADDR_W, DATA_W);
    localparam int SLVERR_BIT = rsp_slverr_bit(DATA_W);

    if (DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1 || REQ_W != $bits(req_data) || RSP_W != $bits(rsp_data)) begin : g_bad_cfg
        $error("apb_master_fsm: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    apb_mst_state_t      state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [DATA_W:0]     rsp_data_q;
    logic                rsp_push_q;

    logic                pop_s;
    logic                req_write_s;
    logic [ADDR_W-1:0]   req_addr_s;
    logic [DATA_W-1:0]   req_wdata_s;
    logic [STRB_W-1:0]   req_strb_s;

    assign req_write_s = req_data[WRITE_BIT];
    assign req_addr_s  = req_data[ADDR_LSB +: ADDR_W];
    assign req_wdata_s = req_data[WDATA_LSB +: DATA_W];
    assign req_strb_s  = req_data[REQ_STRB_LSB +: STRB_W];

    // Pop only from IDLE when a request exists and a response slot is guaranteed
    always_comb begin
        pop_s = 1'b0;
        if (!rst && state_q == IDLE) begin
            pop_s = !req_empty && !rsp_full;
        end else begin
            pop_s = 1'b0;
        end
    end

`ifdef APB_MST_TIMEOUT_EN
    logic tmo_clr_s;
    logic tmo_en_s;
    logic tmo_expire_s;

    assign tmo_clr_s = (state_q == SETUP);
    assign tmo_en_s  = (state_q == ACCESS) && !pready;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmo_clr_s),
        .en_i     (tmo_en_s),
        .expire_o (tmo_expire_s)
    );
`endif

    // Transfer sequencer with registered APB and FIFO-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= {ADDR_W{1'b0}};
            pwdata_q   <= {DATA_W{1'b0}};
            pstrb_q    <= {STRB_W{1'b0}};
            rsp_data_q <= {(DATA_W + 1){1'b0}};
            rsp_push_q <= 1'b0;
        end else begin
            rsp_push_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        paddr_q   <= req_addr_s;
                        pwrite_q  <= req_write_s;
                        pwdata_q  <= req_write_s ? req_wdata_s : {DATA_W{1'b0}};
                        pstrb_q   <= req_write_s ? req_strb_s : {STRB_W{1'b0}};
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_data_q[SLVERR_BIT]                <= pslverr;
                        rsp_data_q[RSP_RDATA_LSB +: DATA_W]   <= pwrite_q ? {DATA_W{1'b0}} : prdata;
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        rsp_push_q <= 1'b1;
                        state_q    <= RESP;
`ifdef APB_MST_TIMEOUT_EN
                    end else if (tmo_expire_s) begin
                        rsp_data_q <= {1'b1, {DATA_W{1'b0}}};
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        rsp_push_q <= 1'b1;
                        state_q    <= RESP;
`endif
                    end else begin
                        state_q <= ACCESS;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign req_pop  = pop_s;
    assign rsp_data = rsp_data_q;
    assign rsp_push = rsp_push_q;
    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pstrb    = pstrb_q;
    assign pprot    = PPROT_DEFAULT;

endmodule
